// File: rtl/gold_nic.sv
// Network interface between a processing element and a router PE port.
// It holds one outgoing packet and one incoming packet behind a 4-entry register window.
module gold_nic #(
  parameter int DATA_W = 64,
  parameter int VC_BIT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  logic [DATA_W-1:0] in_buf;
  logic              in_full;
  logic [DATA_W-1:0] out_buf;
  logic              out_full;

  logic rd_en;
  logic wr_en;
  logic rx_fire;
  logic rd_in_clear;
  logic wr_out_ok;

  // Handshake: a transfer happens on a rising edge only when the sender's
  // send (net_si / net_so) and the receiver's ready (net_ri / net_ro) are both
  // high in that cycle; neither side drops its offer until that edge.
  assign net_ri = !reset && !in_full;
  assign net_so = !reset && out_full && net_ro && (net_polarity == out_buf[VC_BIT]);
  assign net_do = out_buf;

  assign rd_en       = nicEn && !nicWrEn;
  assign wr_en       = nicEn && nicWrEn;
  assign rx_fire     = net_si && net_ri;
  assign rd_in_clear = rd_en && (addr == ADDR_IN_BUF) && in_full;
  // out_full is sampled before the send clears it, so a write that collides
  // with a send is dropped and must be retried.
  assign wr_out_ok   = wr_en && (addr == ADDR_OUT_BUF) && !out_full;

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      unique case (addr)
        ADDR_IN_BUF:   d_out = in_buf;
        ADDR_IN_STAT:  d_out = {{(DATA_W-1){1'b0}}, in_full};
        ADDR_OUT_BUF:  d_out = out_buf;
        ADDR_OUT_STAT: d_out = {{(DATA_W-1){1'b0}}, out_full};
        default:       d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf   <= '0;
      in_full  <= 1'b0;
      out_buf  <= '0;
      out_full <= 1'b0;
    end else begin
      // Receive and clear are mutually exclusive: net_ri is low while full.
      if (rx_fire) begin
        in_buf  <= net_di;
        in_full <= 1'b1;
      end else if (rd_in_clear) begin
        in_full <= 1'b0;
      end

      if (net_so) begin
        out_full <= 1'b0;
      end else if (wr_out_ok) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gold_nic.sv
// Directed bench for gold_nic: register access, send polarity rule, receive
// buffering, collisions and reset discard, with a queue of expected sent packets.
`timescale 1ns/1ps
module tb_gold_nic;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   addr = 2'b00;
  logic [W-1:0] d_in = '0;
  logic [W-1:0] d_out;
  logic         nicEn = 1'b0;
  logic         nicWrEn = 1'b0;
  logic         net_so;
  logic         net_ro = 1'b0;
  logic [W-1:0] net_do;
  logic         net_polarity = 1'b0;
  logic         net_si = 1'b0;
  logic         net_ri;
  logic [W-1:0] net_di = '0;

  int checks = 0;
  int failures = 0;
  int sent = 0;
  logic [W-1:0] exp_q[$];

  localparam logic [W-1:0] P1 = 64'h8000_0000_0000_00AA;
  localparam logic [W-1:0] P2 = 64'h0000_0000_0000_0055;
  localparam logic [W-1:0] P3 = 64'h8000_0000_0000_0077;
  localparam logic [W-1:0] R1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [W-1:0] RA = 64'hA5A5_0000_1111_2222;
  localparam logic [W-1:0] RB = 64'h5A5A_3333_4444_5555;

  gold_nic #(.DATA_W(W), .VC_BIT(63)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  // clock / reset
  always #50 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Settle inputs, score any send happening on this edge, advance one cycle.
  task automatic step();
    #1;
    if (net_so === 1'b1) begin
      sent++;
      if (exp_q.size() == 0) chk("sb_unexpected_send", net_do, '1);
      else chk("sb_send_pkt", net_do, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  // Combinational read with no clock edge, so it never clears in_full.
  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [W-1:0] exp);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
    chk(tag, d_out, exp);
    nicEn = 1'b0;
    #1;
  endtask

  initial begin
    // reset
    #1;
    chk("ri_in_reset", W'(net_ri), W'(0));
    chk("so_in_reset", W'(net_so), W'(0));
    step();
    step();
    reset = 1'b0;
    #1;
    chk("ri_after_reset", W'(net_ri), W'(1));
    chk("so_after_reset", W'(net_so), W'(0));
    chk("do_after_reset", net_do, '0);
    rd_chk("in_stat_reset", 2'b01, '0);
    rd_chk("out_stat_reset", 2'b11, '0);
    rd_chk("in_buf_reset", 2'b00, '0);

    // writes to non-writable registers are ignored
    wr(2'b00, 64'hDEAD);
    wr(2'b01, 64'h1);
    wr(2'b11, 64'h1);
    rd_chk("in_buf_ro", 2'b00, '0);
    rd_chk("in_stat_ro", 2'b01, '0);
    rd_chk("out_stat_ro", 2'b11, '0);
    chk("so_after_ro_writes", W'(net_so), W'(0));

    // send waits for polarity 1 (bit63 = 1)
    net_ro = 1'b1; net_polarity = 1'b0;
    exp_q.push_back(P1);
    wr(2'b10, P1);
    #1;
    chk("so_pol_mismatch", W'(net_so), W'(0));
    chk("do_holds_p1", net_do, P1);
    rd_chk("out_stat_full", 2'b11, 64'd1);
    step();
    net_polarity = 1'b1;
    #1;
    chk("so_pol_match", W'(net_so), W'(1));
    step();
    net_polarity = 1'b0;
    rd_chk("out_stat_after_send", 2'b11, '0);
    net_polarity = 1'b1;
    #1;
    chk("so_empty", W'(net_so), W'(0));
    rd_chk("out_buf_held", 2'b10, P1);

    // back-pressure via net_ro, write while full dropped
    net_ro = 1'b0;
    exp_q.push_back(P2);
    wr(2'b10, P2);
    for (int i = 0; i < 5; i++) begin
      net_polarity = i[0];
      if (i == 2) begin
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = P3;
      end
      #1;
      chk("so_ro_low", W'(net_so), W'(0));
      step();
      nicEn = 1'b0; nicWrEn = 1'b0;
    end
    rd_chk("drop_while_full", 2'b10, P2);
    net_ro = 1'b1; net_polarity = 1'b1;
    #1;
    chk("so_ro_pol_wrong", W'(net_so), W'(0));
    step();
    // send and write collide on the same edge: write is dropped
    net_polarity = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = P3;
    #1;
    chk("so_pol0_send", W'(net_so), W'(1));
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
    rd_chk("out_stat_collide", 2'b11, '0);
    rd_chk("out_buf_collide", 2'b10, P2);
    net_ro = 1'b0;
    wr(2'b10, P3);
    rd_chk("out_stat_retry", 2'b11, 64'd1);
    rd_chk("out_buf_retry", 2'b10, P3);

    // receive one packet and read it out
    net_si = 1'b1; net_di = R1;
    #1;
    chk("ri_empty", W'(net_ri), W'(1));
    step();
    net_si = 1'b0;
    #1;
    chk("ri_full", W'(net_ri), W'(0));
    rd_chk("in_stat_full", 2'b01, 64'd1);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b00;
    #1;
    chk("in_buf_r1", d_out, R1);
    step();
    nicEn = 1'b0;
    rd_chk("in_stat_cleared", 2'b01, '0);
    chk("ri_after_read", W'(net_ri), W'(1));
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b00;
    step();
    nicEn = 1'b0;
    rd_chk("in_stat_empty_read", 2'b01, '0);
    rd_chk("in_buf_stale", 2'b00, R1);

    // back-to-back sends from router: second is refused
    net_si = 1'b1; net_di = RA;
    step();
    net_di = RB;
    #1;
    chk("ri_b2b", W'(net_ri), W'(0));
    step();
    net_si = 1'b0;
    rd_chk("in_buf_keeps_first", 2'b00, RA);
    rd_chk("in_stat_b2b", 2'b01, 64'd1);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b00;
    net_si = 1'b1; net_di = RB;
    #1;
    chk("ri_low_during_read", W'(net_ri), W'(0));
    step();
    nicEn = 1'b0;
    #1;
    chk("ri_after_clear", W'(net_ri), W'(1));
    step();
    net_si = 1'b0;
    rd_chk("in_stat_rb", 2'b01, 64'd1);
    rd_chk("in_buf_rb", 2'b00, RB);

    // reset with both buffers full discards them
    reset = 1'b1; net_ro = 1'b1; net_polarity = 1'b1;
    #1;
    chk("so_reset_full", W'(net_so), W'(0));
    chk("ri_reset_full", W'(net_ri), W'(0));
    step();
    reset = 1'b0;
    #1;
    chk("so_discarded", W'(net_so), W'(0));
    chk("do_discarded", net_do, '0);
    rd_chk("in_stat_discard", 2'b01, '0);
    rd_chk("out_stat_discard", 2'b11, '0);
    rd_chk("in_buf_discard", 2'b00, '0);
    step();
    step();

    // final report
    chk("sent_count", W'(sent), W'(2));
    chk("exp_q_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
